// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable Mealy sequence detector.
// Holds the FSM state enum, the pattern-length clamp and the default counter width.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 16;

    // A zero length behaves as a one-bit pattern; oversize lengths saturate at max_len.
    function automatic int clamp_len(input int len, input int max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked compare of the newest len bits of {history, din} against the pattern.
// Only bits below len take part; len is expected to already be clamped to 1..MAX_LEN.
module seq_det_match #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-2:0] i_hist,
    input  logic               i_din,
    input  logic [MAX_LEN-1:0] i_pat,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_match
);

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;

    assign w_window = {i_hist, i_din};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
    end

    assign o_match = (((w_window ^ i_pat) & w_mask) == '0);

endmodule

// File: rtl/seq_det_prog_mealy.sv
// Programmable Mealy sequence detector with run-time pattern, length and overlap mode.
// Define SEQ_DET_HIT_CNT_EN to build the saturating hit counter; otherwise hit_cnt is tied to 0.
module seq_det_prog_mealy
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               din,
    input  logic               din_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               armed
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_shift;
    logic               w_run;
    logic               w_match;
    logic               w_fill_ok;
    logic               w_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cfg_load)
            w_state_nxt = ST_RUN;
    end

    assign w_run = (r_state == ST_RUN);
    assign armed = w_run;

    seq_det_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .i_hist  (r_hist),
        .i_din   (din),
        .i_pat   (r_pat),
        .i_len   (r_len),
        .o_match (w_match)
    );

    // r_len is never below 1, so len-1 cannot wrap.
    assign w_fill_ok = (r_fill >= (r_len - LEN_W'(1)));
    assign w_hit     = w_run & din_vld & ~cfg_load & w_fill_ok & w_match;
    assign hit       = w_hit;
    assign w_shift   = {r_hist, din};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pat  <= '0;
            r_len  <= LEN_W'(MAX_LEN);
            r_ovl  <= 1'b1;
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_pat  <= cfg_pattern;
            r_len  <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_run && din_vld) begin
            if (w_hit && !r_ovl) begin
                // Non-overlap: consumed bits are discarded; history content no longer matters.
                r_fill <= '0;
            end else begin
                r_hist <= w_shift[MAX_LEN-2:0];
                if (r_fill != LEN_W'(MAX_LEN - 1))
                    r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

`ifdef SEQ_DET_HIT_CNT_EN
    logic [CNT_W-1:0] r_hit_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_hit_cnt <= '0;
        else if (cfg_load)
            r_hit_cnt <= '0;
        else if (w_hit && (r_hit_cnt != {CNT_W{1'b1}}))
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end

    assign hit_cnt = r_hit_cnt;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog_mealy.sv
// Directed testbench for seq_det_prog_mealy (MAX_LEN=8, CNT_W=4).
// Expected hit_cnt values follow SEQ_DET_HIT_CNT_EN as seen by this compile.
module tb_seq_det_prog_mealy;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 4;

    logic               clk;
    logic               rstn;
    logic               din;
    logic               din_vld;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               hit;
    logic [CNT_W-1:0]   hit_cnt;
    logic               armed;

    int n_checks;
    int n_fail;

    seq_det_prog_mealy #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .din         (din),
        .din_vld     (din_vld),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .hit         (hit),
        .hit_cnt     (hit_cnt),
        .armed       (armed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value after n hits since the last load.
    function automatic logic [CNT_W-1:0] cnt_model(input int n);
`ifdef SEQ_DET_HIT_CNT_EN
        if (n > 15)
            return 4'd15;
        return CNT_W'(n);
`else
        return '0;
`endif
    endfunction

    // Drivers: inputs change 1 ns after a rising edge; checks follow 3 ns later.
    task automatic drive(input logic d, input logic v);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        din      = d;
        din_vld  = v;
        #3;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic d, input logic v);
        @(posedge clk);
        #1;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        din         = d;
        din_vld     = v;
        #3;
    endtask

    task automatic test_reset();
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset hit: got %b want 0", hit); end
        n_checks++;
        if (armed !== 1'b0) begin n_fail++; $display("FAIL reset armed: got %b want 0", armed); end
        n_checks++;
        if (hit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset hit_cnt: got %0d want 0", hit_cnt); end
        // IDLE ignores the stream entirely.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (hit !== 1'b0 || armed !== 1'b0) begin
                n_fail++; $display("FAIL idle bit %0d: hit=%b armed=%b want 0/0", i, hit, armed);
            end
        end
    endtask

    task automatic test_overlap();
        logic [4:0] bits;
        logic [4:0] exp;
        bits = 5'b10101;
        exp  = 5'b00101;
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            drive(bits[i], 1'b1);
            n_checks++;
            if (hit !== exp[i]) begin n_fail++; $display("FAIL overlap hit bit %0d: got %b want %b", 5 - i, hit, exp[i]); end
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (armed !== 1'b1) begin n_fail++; $display("FAIL overlap armed: got %b want 1", armed); end
        n_checks++;
        if (hit_cnt !== cnt_model(2)) begin n_fail++; $display("FAIL overlap hit_cnt: got %0d want %0d", hit_cnt, cnt_model(2)); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1010101;
        exp  = 7'b0010001;
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            drive(bits[i], 1'b1);
            n_checks++;
            if (hit !== exp[i]) begin n_fail++; $display("FAIL nonovl hit bit %0d: got %b want %b", 7 - i, hit, exp[i]); end
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (hit_cnt !== cnt_model(2)) begin n_fail++; $display("FAIL nonovl hit_cnt: got %0d want %0d", hit_cnt, cnt_model(2)); end
    endtask

    task automatic test_qualifier_gap();
        logic [2:0] gap_din;
        gap_din = 3'b010;
        load(8'b110, 4'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            drive(gap_din[i], 1'b0);
            n_checks++;
            if (hit !== 1'b0) begin n_fail++; $display("FAIL gap hit cycle %0d: got %b want 0", 2 - i, hit); end
        end
        drive(1'b0, 1'b1);
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL gap qualified 0: got %b want 1", hit); end
        // Self-prefix pattern in overlap mode gives consecutive hits.
        load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (hit !== (i != 0)) begin n_fail++; $display("FAIL prefix hit bit %0d: got %b want %b", i + 1, hit, (i != 0)); end
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (hit_cnt !== cnt_model(3)) begin n_fail++; $display("FAIL prefix hit_cnt: got %0d want %0d", hit_cnt, cnt_model(3)); end
    endtask

    task automatic test_clamp_reload();
        logic [3:0] bits0;
        logic [7:0] bits8;
        logic [2:0] bits3;
        bits0 = 4'b1011;
        load(8'h01, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            drive(bits0[i], 1'b1);
            n_checks++;
            if (hit !== bits0[i]) begin n_fail++; $display("FAIL len0 hit bit %0d: got %b want %b", 4 - i, hit, bits0[i]); end
        end
        bits8 = 8'hA5;
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            drive(bits8[i], 1'b1);
            n_checks++;
            if (hit !== (i == 0)) begin n_fail++; $display("FAIL len15 hit bit %0d: got %b want %b", 8 - i, hit, (i == 0)); end
        end
        // Reload on a bit that would complete 101: no hit, history restarts.
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        load(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reload same-cycle hit: got %b want 0", hit); end
        bits3 = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            drive(bits3[i], 1'b1);
            n_checks++;
            if (hit !== (i == 0)) begin n_fail++; $display("FAIL reload hit bit %0d: got %b want %b", 3 - i, hit, (i == 0)); end
            if (i == 2) begin
                n_checks++;
                if (hit_cnt !== 4'd0) begin n_fail++; $display("FAIL reload hit_cnt: got %0d want 0", hit_cnt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL midreset pre hit: got %b want 1", hit); end
        #1;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (hit !== 1'b0 || armed !== 1'b0 || hit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL midreset async: hit=%b armed=%b cnt=%0d want 0/0/0", hit, armed, hit_cnt);
        end
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (hit !== 1'b0 || armed !== 1'b0) begin
                n_fail++; $display("FAIL midreset after bit %0d: hit=%b armed=%b want 0/0", i, hit, armed);
            end
        end
    endtask

    task automatic test_saturation();
        int n_hit;
        n_hit = 0;
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1);
            n_checks++;
            if (hit !== 1'b1) begin n_fail++; $display("FAIL sat hit %0d: got %b want 1", i, hit); end
            else n_hit++;
            n_checks++;
            if (hit_cnt !== cnt_model(i)) begin n_fail++; $display("FAIL sat hit_cnt step %0d: got %0d want %0d", i, hit_cnt, cnt_model(i)); end
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (hit_cnt !== cnt_model(20)) begin n_fail++; $display("FAIL sat final hit_cnt: got %0d want %0d (%0d hits)", hit_cnt, cnt_model(20), n_hit); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        din         = 1'b0;
        din_vld     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_qualifier_gap();
        test_clamp_reload();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_prog_mealy.md
# seq_det_prog_mealy

Programmable Mealy sequence detector: the next generation of the fixed-pattern detectors. A run-time pattern of 1 to MAX_LEN bits is loaded through a config strobe. Serial bits are then matched one per qualified cycle, in overlapping or non-overlapping mode, with a same-cycle hit output. It sits on a serial bit stream between a bit source and any consumer that needs a per-bit match flag and, optionally, a hit count.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len
- CNT_W, 16, width of hit counter
- clk  input  1  clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- din  input  1  serial data bit
- din_vld  input  1  din qualifier; state advances only when high
- cfg_load  input  1  single-cycle strobe: capture cfg_* and restart
- cfg_pattern  input  MAX_LEN  pattern; bit len-1 is received first, bit 0 last
- cfg_len  input  LEN_W  pattern length; 0 → treated as 1, >MAX_LEN → MAX_LEN
- cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
- hit  output  1  Mealy match flag
- hit_cnt  output  CNT_W  saturating hit count
- armed  output  1  high once a configuration has been loaded

## Operation
- States: IDLE (after reset, no config) and RUN. IDLE→RUN on cfg_load. RUN stays in RUN; cfg_load in RUN reloads.
- Registered config: pat (MAX_LEN), len (clamped), ovl. Reset values: pat=0, len=MAX_LEN, ovl=1.
- History: hist (MAX_LEN-1 bits, newest bit in LSB) and fill (0..MAX_LEN-1, count of valid history bits). Reset values: hist=0, fill=0.
- Match: hit = RUN & din_vld & ~cfg_load & (fill ≥ len-1) & ({hist[len-2:0], din} == pat[len-1:0]). For len=1: hit = RUN & din_vld & ~cfg_load & (din == pat[0]).
- Update on din_vld in RUN without cfg_load:
  - If hit & ~ovl: fill←0. hist is don't-care.
  - Otherwise: hist←{hist[MAX_LEN-3:0], din} and fill←min(fill+1, MAX_LEN-1).
- din_vld low: hist and fill hold; hit=0.
- IDLE: din is ignored; hit=0.
- cfg_load has priority over din_vld in the same cycle. The din of that cycle is discarded, hit=0, hist/fill are cleared, and hit_cnt is cleared.
- armed = (state == RUN).

## Timing
- hit is combinational from din/din_vld and registered state: zero latency, valid in the same cycle as the matching bit.
- State, history, config and counter update on the rising clk edge.
- A config captured at edge N applies to din from cycle N+1 onward.
- rstn assertion at any time, including mid-pattern, asynchronously forces IDLE, clears history, sets hit=0 and hit_cnt=0, and sets armed=0.
- A pattern that is a prefix of itself (e.g. 11 in stream 111) produces consecutive-cycle hits in overlap mode.
- In non-overlap mode, the bits of a matched occurrence are never reused. The next hit needs len fresh bits.

## Configuration
- SEQ_DET_HIT_CNT_EN defined:
  - hit_cnt increments by 1 on every hit cycle and saturates at 2^CNT_W-1.
  - It is cleared on reset and on cfg_load.
- SEQ_DET_HIT_CNT_EN undefined:
  - The counter register is not built and hit_cnt is tied to 0.
  - The port list is unchanged.

## Structure
- Package seq_det_pkg holds:
  - the state enum (ST_IDLE, ST_RUN);
  - the clamp function for cfg_len (0→1, >MAX_LEN→MAX_LEN);
  - the default CNT_W constant.
- Sub-module seq_det_match: purely combinational, computes the masked compare of {hist, din} against pat for a given len. Parameter MAX_LEN.
- The top level holds the FSM, history/fill registers, config registers and the optional counter.

## Test plan
- Overlap: load pattern 101, len=3, ovl=1; stream 1,0,1,0,1 (din_vld=1) → hit on bits 3 and 5; hit_cnt=2.
- Non-overlap: same load with ovl=0; stream 1,0,1,0,1 → hit on bit 3 only; a further 0,1 → hit on bit 7; hit_cnt=2.
- Qualifier gaps and prefix pattern: load 110, len=3; send 1,1 then din_vld=0 for 3 cycles with din toggling, then 0 → hit exactly on the qualified 0. Load 11, len=2, ovl=1; stream 1,1,1,1 → hits on bits 2, 3 and 4.
- Clamp, IDLE and reload:
  - Before any cfg_load, stream 1s → hit=0, armed=0.
  - Load len=0 with pat[0]=1 → every qualified 1 hits.
  - Load len=15 with MAX_LEN=8 → the 8-bit pattern matches.
  - cfg_load in the same cycle as a would-be matching bit → hit=0 and fill restarts.
- Reset mid-pattern: after 1,0 of pattern 101, assert rstn low asynchronously between clk edges → hit=0 immediately, then IDLE and armed=0; after release, the bits 1 alone never hit.
- Counter saturation (macro defined, CNT_W=4): 20 hits with pattern 1, len=1 → hit_cnt=15. With macro undefined → hit_cnt=0 throughout.
